// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Operand widths the datapath is built for.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Step counter width; at least one bit even for the narrowest operands.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mul_add_stage.sv
// rtl/mul_add_stage.sv - ripple-carry adder built from full-adder cells
//   i_a, i_b : N-bit addends
//   i_cin    : carry into bit 0
//   o_sum    : N-bit sum (carry out of the top bit is dropped)
module mul_add_stage #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum
);

    logic [N-1:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i];
        if (i < N - 1) begin : g_carry
            assign w_c[i+1] = (i_a[i] & i_b[i]) | (i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
        end
    end

endmodule

// File: rtl/seq_array_multiplier.sv
// rtl/seq_array_multiplier.sv - iterative shift-add WIDTH x WIDTH multiplier with handshakes
//   clk, rst             : clock, asynchronous active-high reset
//   ena                  : global enable, freezes state and masks handshakes when low
//   in_valid, in_ready   : operand handshake (a, b, signed_mode sampled on accept)
//   out_valid, out_ready : product handshake
//   p                    : registered 2*WIDTH-bit product
module seq_array_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_partial;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_acc_neg;

    // Magnitude of the most negative value wraps to itself, which read as
    // unsigned is exactly its magnitude.
    assign w_mag_a = (signed_mode & a[WIDTH-1]) ? -a : a;
    assign w_mag_b = (signed_mode & b[WIDTH-1]) ? -b : b;

    assign w_partial = r_mag_b[r_cnt] ? ({{WIDTH{1'b0}}, r_mag_a} << r_cnt) : '0;

    mul_add_stage #(.N(2*WIDTH)) u_acc_add (
        .i_a   (r_acc),
        .i_b   (w_partial),
        .i_cin (1'b0),
        .o_sum (w_acc_next)
    );

    // Two's-complement negate of the final accumulator: ~x + 1.
    mul_add_stage #(.N(2*WIDTH)) u_neg_add (
        .i_a   (~w_acc_next),
        .i_b   ('0),
        .i_cin (1'b1),
        .o_sum (w_acc_neg)
    );

    assign in_ready  = ena & ~rst & (r_state == S_IDLE);
    assign out_valid = ena & (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            p       <= '0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == LAST_STEP) begin
                        r_cnt   <= '0;
                        p       <= r_neg ? w_acc_neg : w_acc_next;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// tb/tb_seq_array_multiplier.sv - self-checking bench for seq_array_multiplier
module tb_seq_array_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           ena;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t0       = 0;
    logic [2*W-1:0] sb[$];

    seq_array_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                             input logic sm);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sbv;
        if (sm) begin
            sa  = {{W{ma[W-1]}}, ma};
            sbv = {{W{mb[W-1]}}, mb};
            return sa * sbv;
        end
        return {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic accept(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sm,
                          input logic [2*W-1:0] exp, input bit push);
        @(negedge clk);
        a = ia; b = ib; signed_mode = sm; in_valid = 1'b1;
        check("in_ready_at_accept", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        t0 = cyc;
        if (push) sb.push_back(exp);
        in_valid    = 1'b0;
        a           = W'($urandom);
        b           = W'($urandom);
        signed_mode = ~sm;
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        bit             seen;
        logic [2*W-1:0] e;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 64'(seen), 64'(1));
        check({tag, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        check({tag, "_p"}, 64'(p), 64'(e));
    endtask

    task automatic handshake(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_idle_valid"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           rs;
        logic [2*W-1:0] exp_bp;

        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; signed_mode = 1'b0;

        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_p", 64'(p), 64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        accept(8'd13, 8'd11, 1'b0, 16'h008F, 1'b1);
        wait_result("u13x11", 8);
        handshake("u13x11");

        accept(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        wait_result("uFFxFF", 8);
        handshake("uFFxFF");

        accept(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        wait_result("s80x80", 8);
        handshake("s80x80");

        accept(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1);
        wait_result("sFDx05", 8);
        handshake("sFDx05");

        accept(8'h7F, 8'h80, 1'b1, 16'hC080, 1'b1);
        wait_result("s7Fx80", 8);
        handshake("s7Fx80");

        for (int k = 0; k < 4; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            accept(ra, rb, rs, model(ra, rb, rs), 1'b1);
            wait_result("rand", 8);
            handshake("rand");
        end

        // Backpressure: consumer stalls five cycles while a new operand is offered.
        out_ready = 1'b0;
        exp_bp = model(8'h9C, 8'h37, 1'b0);
        accept(8'h9C, 8'h37, 1'b0, exp_bp, 1'b1);
        wait_result("bp", 8);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; a = 8'd1; b = 8'd1; signed_mode = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_p_stable", 64'(p), 64'(exp_bp));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 64'(out_valid), 64'(0));
        check("bp_release_ready", 64'(in_ready), 64'(1));
        check("bp_release_p", 64'(p), 64'(exp_bp));

        // Enable dropped for three cycles mid-computation.
        accept(8'hC3, 8'h5A, 1'b1, model(8'hC3, 8'h5A, 1'b1), 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        #1;
        check("ena_low_in_ready", 64'(in_ready), 64'(0));
        check("ena_low_out_valid", 64'(out_valid), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("ena_low_hold_valid", 64'(out_valid), 64'(0));
        end
        ena = 1'b1;
        wait_result("ena_gap", 11);
        handshake("ena_gap");

        // Reset in the middle of a computation discards it.
        accept(8'd200, 8'd100, 1'b0, '0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_p", 64'(p), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_release_ready", 64'(in_ready), 64'(1));

        accept(8'd7, 8'd6, 1'b0, 16'd42, 1'b1);
        wait_result("u7x6", 8);
        handshake("u7x6");

        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_array_multiplier.md
# seq_array_multiplier

Parametrised, iterative shift-add multiplier that succeeds the fixed 4x4 combinational array multiplier. It computes a WIDTH x WIDTH product over WIDTH clock cycles, with selectable signed/unsigned mode and valid/ready handshakes on both sides. It sits between an operand source and a result consumer in the tile datapath and trades throughput for area when WIDTH grows beyond 4.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- ena  input  1  global enable; low freezes all state and masks both handshakes
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (IDLE and ena)
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- signed_mode  input  1  1 = two's-complement operands/product, 0 = unsigned; sampled with operands
- out_valid  output  1  product valid (DONE and ena)
- out_ready  input  1  consumer accepts product
- p  output  2*WIDTH  product, registered

## Operation
- FSM states: IDLE, BUSY, DONE. Reset -> IDLE; p = 0, in_ready = 0 while rst high, out_valid = 0, counter = 0.
- IDLE: in_ready = ena. Accept on in_valid & in_ready: latch mag_a = |a|, mag_b = |b| if signed_mode else raw; neg = signed_mode & (a[W-1] ^ b[W-1]); clear accumulator; counter = 0; -> BUSY.
- BUSY: each enabled cycle, if mag_b[counter] add mag_a << counter into 2W-bit accumulator; counter++. After step WIDTH-1 -> DONE, registering p = neg ? -acc : acc in the same edge.
- DONE: out_valid = ena; p held stable. On out_valid & out_ready -> IDLE. p keeps last value in IDLE.
- ena low: no state, counter, accumulator or p change; in_ready = out_valid = 0.
- Width rules: |most-negative| fits WIDTH-bit unsigned; (-2^(W-1))^2 = 2^(2W-2) fits 2W-bit signed; no overflow possible. Unsigned mode ignores signed_mode-dependent negation.
- Operand changes outside the accept cycle have no effect.
- rst asserted mid-BUSY or mid-DONE: immediate return to IDLE, in-flight result discarded, p = 0.

## Timing
- Accept at edge E0; iteration steps at E1..EW; out_valid high from after EW (latency WIDTH cycles with ena high).
- Earliest next accept: edge after the output handshake; throughput one product per WIDTH+2 cycles minimum.
- in_ready and out_valid are combinational from state and ena only; never from in_valid/out_ready.
- ena low for k cycles during BUSY extends latency by exactly k.
- Backpressure: out_ready low holds DONE indefinitely with p stable.

## Structure
- Shared package mult_pkg: state enum (IDLE, BUSY, DONE), WIDTH legality constants, counter width = clog2(WIDTH).
- One sub-module: mul_add_stage, a 2W-bit ripple adder built from full-adder cells (sum = a^b^c, carry = majority), used for the accumulate step; final negation uses the same stage with inverted input and carry-in 1.

## Test plan
- WIDTH=8, unsigned, a=13, b=11, out_ready=1 -> out_valid exactly 8 cycles after accept, p=143 (0x008F), back to IDLE next cycle.
- WIDTH=8, unsigned, a=255, b=255 -> p=0xFE01; signed_mode=1, a=0x80, b=0x80 -> p=0x4000.
- WIDTH=8, signed, a=0xFD (-3), b=5 -> p=0xFFF1; a=0x7F, b=0x80 -> p=0xC080 (-16256).
- Backpressure: out_ready=0 for 5 cycles after DONE -> out_valid stays 1, p stable, in_ready 0; new in_valid ignored until handshake.
- ena toggled low 3 cycles mid-BUSY -> out_valid at 8+3 cycles, correct product; in_ready/out_valid 0 while ena low.
- rst pulsed at step 4 of a=200,b=100 -> p=0, IDLE, in_ready next cycle; following 7*6 yields p=42.
